// File: rtl/ram2_arbiter.sv
// RAM2 port arbiter: serves one IF or MEM access at a time (MEM has priority),
// drives registered addr/data/read toward RAM2 and returns the result with an ack pulse.
module ram2_arbiter #(
  parameter int DATA_W     = 16,
  parameter int CPU_ADDR_W = 16,
  parameter int RAM_ADDR_W = 18,
  parameter logic [RAM_ADDR_W-CPU_ADDR_W-1:0] PAGE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [CPU_ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ack,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [CPU_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ack,
  output logic                  stall_o,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_data,
  output logic                  ram_read,
  input  logic [DATA_W-1:0]     ram_res,
  output logic [1:0]            dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: a master holds req high until it sees its one-cycle ack; the ack
  // cycle is the last cycle req may be high for that access.
  logic [1:0]            state_q, state_d;
  logic                  gnt_if_q, gnt_if_d;
  logic                  gnt_mem_q, gnt_mem_d;
  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_data_q, ram_data_d;
  logic                  ram_read_q, ram_read_d;
  logic                  if_ack_q, if_ack_d;
  logic                  mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;

  always_comb begin
    state_d     = state_q;
    gnt_if_d    = gnt_if_q;
    gnt_mem_d   = gnt_mem_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_read_d  = ram_read_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          gnt_mem_d  = 1'b1;
          ram_addr_d = {PAGE, mem_addr};
          ram_data_d = mem_wdata;
          ram_read_d = mem_we;
          state_d    = S_ACC;
        end else if (if_req) begin
          gnt_if_d   = 1'b1;
          ram_addr_d = {PAGE, if_addr};
          ram_read_d = 1'b0;
          state_d    = S_ACC;
        end
      end
      S_ACC: begin
        // ram_read low here means the access was a read (IF is always a read)
        if (!ram_read_q) begin
          if (gnt_mem_q) mem_rdata_d = ram_res;
          if (gnt_if_q)  if_rdata_d  = ram_res;
        end
        ram_read_d = 1'b0;
        mem_ack_d  = gnt_mem_q;
        if_ack_d   = gnt_if_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        gnt_if_d  = 1'b0;
        gnt_mem_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        gnt_if_d   = 1'b0;
        gnt_mem_d  = 1'b0;
        ram_read_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_if_q    <= 1'b0;
      gnt_mem_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_read_q  <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_if_q    <= gnt_if_d;
      gnt_mem_q   <= gnt_mem_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_read_q  <= ram_read_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // ram_read comes straight from a flop so RAM2's WE never sees a glitch
  assign ram_read    = ram_read_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign if_ack      = if_ack_q;
  assign mem_ack     = mem_ack_q;
  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign stall_o     = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Bench for ram2_arbiter: directed accesses against a negedge RAM2 model, with a
// scoreboard that checks returned words whenever an ack appears.
module tb_ram2_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall_o;
  logic [17:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_read;
  logic [15:0] ram_res = '0;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [15:0] if_exp_q[$];
  logic [15:0] mem_exp_q[$];
  logic [15:0] mem_model_rdata = '0;
  logic [15:0] ram_mem [0:1023];

  ram2_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_o(stall_o),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_read(ram_read), .ram_res(ram_res),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM2 model: acts in the low phase, result latched on negedge
  always @(negedge clk) begin
    if (ram_read) ram_mem[ram_addr[9:0]] <= ram_data;
    else          ram_res <= ram_mem[ram_addr[9:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && if_ack) begin
      if (if_exp_q.size() == 0) chk("if_ack_unexpected", 32'(if_ack), 32'd0);
      else chk("if_rdata", 32'(if_rdata), 32'(if_exp_q.pop_front()));
    end
    if (!rst && mem_ack) begin
      if (mem_exp_q.size() == 0) chk("mem_ack_unexpected", 32'(mem_ack), 32'd0);
      else chk("mem_rdata", 32'(mem_rdata), 32'(mem_exp_q.pop_front()));
    end
  end

  // Called #1 after a posedge (the IDLE cycle); returns #1 after the posedge ending ack.
  task automatic access(input bit is_mem, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rd_word,
                        input bit keep, input string name);
    int c;
    bit got;
    if (is_mem) begin
      if (!we) mem_model_rdata = rd_word;
      mem_exp_q.push_back(mem_model_rdata);
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_exp_q.push_back(rd_word);
      if_req = 1'b1; if_addr = addr;
    end
    c = 0;
    got = 0;
    while (!got && c < 20) begin
      @(negedge clk);
      chk($sformatf("%s_ram_read_c%0d", name, c), 32'(ram_read),
          32'((c == 1) && is_mem && we));
      if (c == 1) begin
        chk({name, "_ram_addr"}, 32'(ram_addr), {14'd0, addr});
        chk({name, "_state_acc"}, 32'(dbg_state), 32'd1);
        if (is_mem && we) chk({name, "_ram_data"}, 32'(ram_data), 32'(wdata));
      end
      if (is_mem ? mem_ack : if_ack) begin
        got = 1;
        chk({name, "_latency"}, 32'(c), 32'd2);
      end else begin
        chk($sformatf("%s_stall_c%0d", name, c), 32'(stall_o), 32'd1);
      end
      c++;
    end
    if (!got) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (is_mem) mem_req = 1'b0;
      else        if_req  = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = 16'h0000;
    ram_mem[10'h040] = 16'h1234;
    ram_mem[10'h041] = 16'h7777;
    ram_mem[10'h200] = 16'h5A5A;
    ram_mem[10'h000] = 16'hA000;
    ram_mem[10'h001] = 16'hA111;
    ram_mem[10'h002] = 16'hA222;
    ram_mem[10'h003] = 16'hA333;

    // 1: async reset mid-cycle
    if_req = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_ram_read", 32'(ram_read), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    chk("rst_acks", {30'd0, if_ack, mem_ack}, 32'd0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_stall_req", 32'(stall_o), 32'd1);
    if_req = 1'b0;
    #1;
    chk("rst_stall_noreq", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 2: IF read
    access(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234, 1'b0, "if_read");

    // 3: MEM write then read back
    access(1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 1'b0, "mem_write");
    access(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 1'b0, "mem_read");
    chk("if_rdata_untouched", 32'(if_rdata), 32'h1234);

    // 4: simultaneous requests, MEM first
    if_exp_q.push_back(16'h7777);
    mem_model_rdata = 16'h5A5A;
    mem_exp_q.push_back(16'h5A5A);
    if_req = 1'b1; if_addr = 16'h0041;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0200;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("both_mem_ack_c%0d", c), 32'(mem_ack), 32'(c == 2));
      chk($sformatf("both_if_ack_c%0d", c), 32'(if_ack), 32'(c == 5));
      chk($sformatf("both_stall_c%0d", c), 32'(stall_o), 32'(c <= 4));
      @(posedge clk); #1;
      if (c == 2) mem_req = 1'b0;
      if (c == 5) if_req = 1'b0;
    end

    // 5: reset during ACC of a MEM write
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0300; mem_wdata = 16'hDEAD;
    @(posedge clk); #3;
    chk("abort_ram_read_acc", 32'(ram_read), 32'd1);
    chk("abort_state_acc", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ram_read_rst", 32'(ram_read), 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_model_rdata = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_ack_c%0d", c), 32'(mem_ack), 32'd0);
      chk($sformatf("abort_idle_c%0d", c), 32'(dbg_state), 32'd0);
    end
    chk("abort_rdata", {if_rdata, mem_rdata}, 32'd0);
    @(posedge clk); #1;

    // 6: back-to-back fetches with req held
    access(1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA000, 1'b1, "fetch0");
    access(1'b0, 1'b0, 16'h0001, 16'h0000, 16'hA111, 1'b1, "fetch1");
    access(1'b0, 1'b0, 16'h0002, 16'h0000, 16'hA222, 1'b1, "fetch2");
    access(1'b0, 1'b0, 16'h0003, 16'h0000, 16'hA333, 1'b0, "fetch3");
    chk("fetch_mem_rdata_hold", 32'(mem_rdata), 32'd0);

    repeat (3) @(posedge clk);
    chk("if_queue_empty", 32'(if_exp_q.size()), 32'd0);
    chk("mem_queue_empty", 32'(mem_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
